// File: rtl/modmul_pkg.sv
// modmul_pkg: shared constants and types for the modular-multiplier mode
// arbiter.
//   Q         - prime modulus of the shared multiplier
//   DATA_W    - operand/result width
//   MUL_LAT   - multiplier latency, issue cycle to result-valid cycle
//   state_e   - arbiter FSM states (MODE0, MODE1, DRAIN)
//   SRC_MODE* - source encoding carried with every in-flight operation
package modmul_pkg;

  localparam int Q       = 12289;
  localparam int DATA_W  = 14;
  localparam int MUL_LAT = 4;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic SRC_MODE0 = 1'b0;
  localparam logic SRC_MODE1 = 1'b1;

endpackage

// File: rtl/modmul_inflight_pipe.sv
// modmul_inflight_pipe: DEPTH-deep shift register of {valid, src, tag} that
// mirrors the multiplier pipeline, so the head entry lines up with mul_c.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   push_valid_i/src_i/tag_i    - entry entering the pipe this cycle
//   head_valid_o/src_o/tag_o    - oldest entry, presented with the result
//   any_valid_o                 - some stage (head included) holds an entry
module modmul_inflight_pipe
  import modmul_pkg::*;
#(
  parameter int DEPTH = MUL_LAT,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  input  logic             push_src_i,
  input  logic [TAG_W-1:0] push_tag_i,
  output logic             head_valid_o,
  output logic             head_src_o,
  output logic [TAG_W-1:0] head_tag_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] src_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      src_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      valid_q  <= {valid_q[DEPTH-2:0], push_valid_i};
      src_q    <= {src_q[DEPTH-2:0], push_src_i};
      tag_q[0] <= push_tag_i;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign head_valid_o = valid_q[DEPTH-1];
  assign head_src_o   = src_q[DEPTH-1];
  assign head_tag_o   = tag_q[DEPTH-1];
  assign any_valid_o  = |valid_q;

endmodule

// File: rtl/modmul_mode_arbiter.sv
// modmul_mode_arbiter: shares one modular multiplier (sel not pipelined)
// between a mode-0 requester and a mode-1 requester. Issues bursts per mode,
// drains the multiplier before flipping mul_sel, and returns each result
// tagged with its source, in issue order.
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   req0_valid/ready/a/tag            - mode-0 request (mul_b forced to 0)
//   req1_valid/ready/a/b/tag          - mode-1 request
//   mul_a, mul_b, mul_sel, mul_c      - multiplier interface
//   rsp_valid/src/tag/data            - result stream, no backpressure
//   stat_issue0/issue1/switch         - wrapping counters, only when
//                                       MODMUL_ARB_STATS_EN is defined
//   dbg_state                         - current FSM state (state_e encoding)
// Handshake: a request transfers in any cycle where valid and ready are both
// high; ready is combinational from state, burst count and the other valid,
// and a requester may drop valid at any time before transfer.
module modmul_mode_arbiter
  import modmul_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_sel,
  input  logic [DATA_W-1:0] mul_c,
  output logic              rsp_valid,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data,
`ifdef MODMUL_ARB_STATS_EN
  output logic [31:0]       stat_issue0,
  output logic [31:0]       stat_issue1,
  output logic [31:0]       stat_switch,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e           state_q;
  logic             mul_sel_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;
  logic             burst_full;
  logic             issue0;
  logic             issue1;
  logic             push_src;
  logic [TAG_W-1:0] push_tag;
  logic             pipe_any;
  logic             drain_done;

  assign burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));

  // Readies are held low while in reset so nothing is accepted then.
  assign req0_ready = rst && (state_q == MODE0) && !(burst_full && req1_valid);
  assign req1_ready = rst && (state_q == MODE1) && !(burst_full && req0_valid);

  assign issue0 = req0_valid && req0_ready;
  assign issue1 = req1_valid && req1_ready;

  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    push_src = SRC_MODE0;
    push_tag = '0;
    if (issue0) begin
      mul_a    = req0_a;
      push_tag = req0_tag;
    end else if (issue1) begin
      mul_a    = req1_a;
      mul_b    = req1_b;
      push_src = SRC_MODE1;
      push_tag = req1_tag;
    end
  end

  assign burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + 1'b1;

  // The head entry counts as in flight, so the switch waits until the last
  // old-mode result has been presented before mul_sel changes.
  assign drain_done = (state_q == DRAIN) && !pipe_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MODE0;
      mul_sel_q   <= SRC_MODE0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        MODE0: begin
          if (issue0) burst_cnt_q <= burst_cnt_d;
          if (req1_valid && (!req0_valid || burst_full)) state_q <= DRAIN;
        end
        MODE1: begin
          if (issue1) burst_cnt_q <= burst_cnt_d;
          if (req0_valid && (!req1_valid || burst_full)) state_q <= DRAIN;
        end
        DRAIN: begin
          // The target is always the mode opposite the current mul_sel.
          if (!pipe_any) begin
            state_q     <= mul_sel_q ? MODE0 : MODE1;
            mul_sel_q   <= ~mul_sel_q;
            burst_cnt_q <= '0;
          end
        end
        default: state_q <= MODE0;
      endcase
    end
  end

  modmul_inflight_pipe #(
    .DEPTH (MUL_LAT),
    .TAG_W (TAG_W)
  ) u_pipe (
    .clk          (clk),
    .rst_n        (rst),
    .push_valid_i (issue0 || issue1),
    .push_src_i   (push_src),
    .push_tag_i   (push_tag),
    .head_valid_o (rsp_valid),
    .head_src_o   (rsp_src),
    .head_tag_o   (rsp_tag),
    .any_valid_o  (pipe_any)
  );

  assign mul_sel   = mul_sel_q;
  assign rsp_data  = mul_c;
  assign dbg_state = state_q;

`ifdef MODMUL_ARB_STATS_EN
  logic [31:0] stat_issue0_q;
  logic [31:0] stat_issue1_q;
  logic [31:0] stat_switch_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issue0_q <= '0;
      stat_issue1_q <= '0;
      stat_switch_q <= '0;
    end else begin
      if (issue0) stat_issue0_q <= stat_issue0_q + 32'd1;
      if (issue1) stat_issue1_q <= stat_issue1_q + 32'd1;
      if (drain_done) stat_switch_q <= stat_switch_q + 32'd1;
    end
  end

  assign stat_issue0 = stat_issue0_q;
  assign stat_issue1 = stat_issue1_q;
  assign stat_switch = stat_switch_q;
`else
  logic unused_drain_done;
  assign unused_drain_done = drain_done;
`endif

endmodule

// File: tb/tb_modmul_mode_arbiter.sv
`timescale 1ns/1ps
module tb_modmul_mode_arbiter;
  import modmul_pkg::*;

  localparam int TAG_W     = 4;
  localparam int MAX_BURST = 16;
  localparam int C0        = 10810;  // mode-0 constant-path multiplier
  localparam int IW        = TAG_W + 2 * DATA_W;
  localparam int EW        = 32 + 1 + TAG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req1_a, req1_b;
  logic [TAG_W-1:0]  req0_tag, req1_tag;
  logic [DATA_W-1:0] mul_a, mul_b, mul_c, rsp_data;
  logic              mul_sel, rsp_valid, rsp_src;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        dbg_state;
`ifdef MODMUL_ARB_STATS_EN
  logic [31:0]       stat_issue0, stat_issue1, stat_switch;
  int                m_iss0, m_iss1, m_sw;
`endif

  modmul_mode_arbiter #(.TAG_W(TAG_W), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_sel    (mul_sel),
    .mul_c      (mul_c),
    .rsp_valid  (rsp_valid),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag),
    .rsp_data   (rsp_data),
`ifdef MODMUL_ARB_STATS_EN
    .stat_issue0(stat_issue0),
    .stat_issue1(stat_issue1),
    .stat_switch(stat_switch),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- multiplier model ----------------
  function automatic logic [DATA_W-1:0] ref_mul(input logic sel, input int a, input int b);
    if (sel) return DATA_W'((a * b) % Q);
    return DATA_W'((a * C0) % Q);
  endfunction

  // Operands travel MUL_LAT stages; sel is read at the output, as in the
  // real multiplier, so a premature mul_sel flip corrupts in-flight results.
  logic [DATA_W-1:0] pa [MUL_LAT];
  logic [DATA_W-1:0] pb [MUL_LAT];
  always @(posedge clk) begin
    pa[0] <= mul_a;
    pb[0] <= mul_b;
    for (int i = 1; i < MUL_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign mul_c = ref_mul(mul_sel, int'(pa[MUL_LAT-1]), int'(pb[MUL_LAT-1]));

  // ---------------- scoreboard / reference model ----------------
  int n_vec;
  int n_err;
  int cyc;
  int gap_pct;
  logic [IW-1:0] s0_q[$];           // pending requests {tag, a, b}
  logic [IW-1:0] s1_q[$];
  logic [EW-1:0] exp_q[$];          // expected results {due, src, tag, data}
  logic [DATA_W-1:0] last_rsp;
  int   m_mode;                     // mode currently granted
  bit   m_drain;                    // switching, waiting for results
  int   m_cnt;                      // issues in this burst (saturating)

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [EW-1:0] e;
    logic [1:0]    es;
    bit   full, e_r0, e_r1, hs0, hs1, own_v, oth_v;
    int   pending;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_mode = 0; m_drain = 0; m_cnt = 0;
`ifdef MODMUL_ARB_STATS_EN
      m_iss0 = 0; m_iss1 = 0; m_sw = 0;
`endif
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_src", rsp_src, 0);
      check_eq("rst_rsp_tag", rsp_tag, 0);
      check_eq("rst_ready0", req0_ready, 0);
      check_eq("rst_ready1", req1_ready, 0);
      check_eq("rst_mul_sel", mul_sel, 0);
      check_eq("rst_state", dbg_state, 32'(MODE0));
      return;
    end
    // Entries due this cycle still count as in flight for the drain rule.
    pending = exp_q.size();
    if (pending > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      e = exp_q.pop_front();
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_src", rsp_src, e[DATA_W + TAG_W]);
      check_eq("rsp_tag", rsp_tag, e[DATA_W +: TAG_W]);
      check_eq("rsp_data", rsp_data, e[DATA_W-1:0]);
      last_rsp = rsp_data;
    end else begin
      check_eq("rsp_idle", rsp_valid, 0);
    end

    full = (m_cnt == MAX_BURST);
    e_r0 = !m_drain && m_mode == 0 && !(full && req1_valid);
    e_r1 = !m_drain && m_mode == 1 && !(full && req0_valid);
    es   = m_drain ? 2'(DRAIN) : (m_mode == 1 ? 2'(MODE1) : 2'(MODE0));
    check_eq("ready0", req0_ready, e_r0);
    check_eq("ready1", req1_ready, e_r1);
    check_eq("mul_sel", mul_sel, m_mode[0]);
    check_eq("state", dbg_state, es);

    hs0 = req0_valid && e_r0;
    hs1 = req1_valid && e_r1;
    if (hs0) begin
      check_eq("mul_a0", mul_a, req0_a);
      check_eq("mul_b0", mul_b, 0);
      exp_q.push_back({32'(cyc + MUL_LAT), 1'b0, req0_tag, ref_mul(1'b0, int'(req0_a), 0)});
      void'(s0_q.pop_front());
    end else if (hs1) begin
      check_eq("mul_a1", mul_a, req1_a);
      check_eq("mul_b1", mul_b, req1_b);
      exp_q.push_back({32'(cyc + MUL_LAT), 1'b1, req1_tag, ref_mul(1'b1, int'(req1_a), int'(req1_b))});
      void'(s1_q.pop_front());
    end else begin
      check_eq("mul_ab_idle", {mul_a, mul_b}, 0);
    end
`ifdef MODMUL_ARB_STATS_EN
    if (hs0) m_iss0++;
    if (hs1) m_iss1++;
`endif

    if (m_drain) begin
      if (pending == 0) begin
        m_mode  = 1 - m_mode;
        m_drain = 0;
        m_cnt   = 0;
`ifdef MODMUL_ARB_STATS_EN
        m_sw++;
`endif
      end
    end else begin
      own_v = (m_mode == 1) ? req1_valid : req0_valid;
      oth_v = (m_mode == 1) ? req0_valid : req1_valid;
      if (oth_v && (!own_v || full)) m_drain = 1;
      if ((hs0 || hs1) && m_cnt < MAX_BURST) m_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    logic [IW-1:0] it0, it1;
    it0 = (s0_q.size() > 0) ? s0_q[0] : '0;
    it1 = (s1_q.size() > 0) ? s1_q[0] : '0;
    req0_valid = (s0_q.size() > 0) && ($urandom_range(0, 99) >= 32'(gap_pct));
    req1_valid = (s1_q.size() > 0) && ($urandom_range(0, 99) >= 32'(gap_pct));
    req0_tag = it0[2*DATA_W +: TAG_W];
    req0_a   = it0[DATA_W +: DATA_W];
    req1_tag = it1[2*DATA_W +: TAG_W];
    req1_a   = it1[DATA_W +: DATA_W];
    req1_b   = it1[DATA_W-1:0];
  endtask

  task automatic run_cycle();
    drive_inputs();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((s0_q.size() > 0 || s1_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    check_eq("idle_timeout", 32'(n < budget), 1);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    s0_q.delete();
    s1_q.delete();
    repeat (n) run_cycle();
    rst = 1'b1;
    run_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0; gap_pct = 0;
    m_mode = 0; m_drain = 0; m_cnt = 0;
    last_rsp = '1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_tag = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    rst = 1'b0;
    apply_reset(3);

    // Single mode-1 op from idle MODE0: forces a drain then a switch.
    last_rsp = '1;
    s1_q.push_back({4'd3, 14'd100, 14'd200});
    run_until_idle(60);
    check_eq("m1_single_data", last_rsp, 7711);

    // Single mode-0 op: switches back.
    last_rsp = '1;
    s0_q.push_back({4'd5, 14'd1, 14'd0});
    run_until_idle(60);
    check_eq("m0_single_data", last_rsp, 10810);

    // Back-to-back mode-1 stream.
    for (int i = 0; i < 8; i++) s1_q.push_back({4'(i), 14'(i), 14'(i + 1)});
    run_until_idle(80);
    check_eq("m1_stream_last", last_rsp, 56);

    // Both requesters saturated from reset: bursts of MAX_BURST alternate.
    apply_reset(2);
    for (int i = 0; i < 40; i++) begin
      s0_q.push_back({4'(i), 14'($urandom_range(0, Q - 1)), 14'd0});
      s1_q.push_back({4'(i), 14'($urandom_range(0, Q - 1)), 14'($urandom_range(0, Q - 1))});
    end
    run_until_idle(400);

    // Randomized traffic with valid gaps.
    gap_pct = 35;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0)
        s0_q.push_back({4'($urandom_range(0, 15)), 14'($urandom_range(0, Q - 1)), 14'd0});
      else
        s1_q.push_back({4'($urandom_range(0, 15)), 14'($urandom_range(0, Q - 1)),
                        14'($urandom_range(0, Q - 1))});
    end
    run_until_idle(3000);
    gap_pct = 0;

    // Reset while three mode-0 ops are in flight: their results vanish.
    apply_reset(2);
    for (int i = 0; i < 3; i++) s0_q.push_back({4'(i + 1), 14'(i + 2), 14'd0});
    for (int n = 0; n < 20 && s0_q.size() > 0; n++) run_cycle();
    check_eq("pre_rst_issued", s0_q.size(), 0);
    apply_reset(2);
    repeat (8) run_cycle();
    last_rsp = '1;
    s0_q.push_back({4'd9, 14'd7, 14'd0});
    run_until_idle(60);
    check_eq("post_rst_data", last_rsp, 1936);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) s0_q.push_back({4'(i), 14'(i + 11), 14'd0});
    s1_q.push_back({4'd6, 14'd40, 14'd50});
    repeat (6) run_cycle();
    apply_reset(1);
    repeat (6) run_cycle();

`ifdef MODMUL_ARB_STATS_EN
    s1_q.push_back({4'd1, 14'd2, 14'd3});
    run_until_idle(60);
    check_eq("stat_issue0", stat_issue0, 32'(m_iss0));
    check_eq("stat_issue1", stat_issue1, 32'(m_iss1));
    check_eq("stat_switch", stat_switch, 32'(m_sw));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
